// File: rtl/ac97_pkg.sv
// ac97_pkg: codec register indices, init table depth, arbiter states and volume encoding (host states need AC97_HOST_PORT_EN)
package ac97_pkg;
  localparam logic [6:0] REG_MASTER = 7'h02;
  localparam logic [6:0] REG_HP = 7'h04;
  localparam logic [6:0] REG_LINE_IN = 7'h10;
  localparam logic [6:0] REG_PCM_OUT = 7'h18;
  localparam logic [6:0] REG_REC_SEL = 7'h1A;
  localparam logic [15:0] PCM_OUT_GAIN = 16'h0808;
  localparam logic [15:0] REC_SEL_VAL = 16'h0404;
  localparam int INIT_DEPTH = 5;
  localparam logic [2:0] LAST_IDX = 3'(INIT_DEPTH - 1);
  typedef enum logic [2:0] {
    WAIT_READY,
    INIT_ISSUE,
    INIT_WAIT,
`ifdef AC97_HOST_PORT_EN
    ARB,
    HOST_ISSUE,
    HOST_WAIT
`else
    ARB
`endif
  } state_t;
  function automatic logic [15:0] vol_enc(input logic [4:0] v);
    return {3'b000, 5'd31 - v, 3'b000, 5'd31 - v};
  endfunction
endpackage

// File: rtl/ac97_cmd_arbiter_if.sv
// ac97_cmd_arbiter_if: runtime host register-write port (level request, one-cycle ack)
interface ac97_cmd_arbiter_if;
  logic host_req;
  logic [6:0] host_addr;
  logic [15:0] host_data;
  logic host_ack;
  modport master(output host_req, host_addr, host_data, input host_ack);
  modport slave(input host_req, host_addr, host_data, output host_ack);
endinterface

// File: rtl/ac97_done_sync.sv
// ac97_done_sync: brings the bit-clock done flag into clkout and flags its rising edge
module ac97_done_sync (
  input  logic clkout,
  input  logic Rst,
  input  logic done,
  output logic done_rise
);
  logic [2:0] sr;
  // two synchronizer flops followed by one history flop for the edge compare
  always_ff @(posedge clkout or posedge Rst)
    if (Rst) sr <= '0;
    else sr <= {sr[1:0], done};
  assign done_rise = sr[1] & ~sr[2];
endmodule

// File: rtl/ac97_cmd_arbiter.sv
// ac97_cmd_arbiter: sends the codec init table then arbitrates host register writes (host port needs AC97_HOST_PORT_EN)
module ac97_cmd_arbiter
  import ac97_pkg::*;
#(
  parameter logic [4:0] MasterVolume = 5'd22,
  parameter logic [4:0] HPVolume = 5'd22,
  parameter logic [4:0] LineInVolume = 5'd22,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clkout,
  input  logic Rst,
  input  logic codec_ready,
  input  logic done,
  ac97_cmd_arbiter_if.slave host,
  output logic [7:0] Register,
  output logic [15:0] command,
  output logic validate,
  output logic init_done,
  output logic timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [2:0] idx;
  logic [CW-1:0] cnt;
  logic done_rise, expired;
  logic [22:0] entry;
  ac97_done_sync u_sync (.clkout(clkout), .Rst(Rst), .done(done), .done_rise(done_rise));
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
`ifdef AC97_HOST_PORT_EN
  logic [6:0] hold_addr;
  logic [15:0] hold_data;
  logic ack;
  assign host.host_ack = ack;
`else
  logic unused_host;
  assign unused_host = ^{host.host_req, host.host_addr, host.host_data};
  assign host.host_ack = 1'b0;
`endif
  // init table entry {register index, data} selected by the table index
  always_comb
    entry = idx == 3'd0 ? {REG_MASTER, vol_enc(MasterVolume)}
          : idx == 3'd1 ? {REG_HP, vol_enc(HPVolume)}
          : idx == 3'd2 ? {REG_LINE_IN, vol_enc(LineInVolume)}
          : idx == 3'd3 ? {REG_PCM_OUT, PCM_OUT_GAIN}
          : {REG_REC_SEL, REC_SEL_VAL};
  // command sequencer: init table, then host writes; a codec_ready drop restarts from entry 0
  always_ff @(posedge clkout or posedge Rst)
    if (Rst) begin
      state <= WAIT_READY;
      idx <= '0;
      cnt <= '0;
      Register <= '0;
      command <= '0;
      validate <= 1'b0;
      init_done <= 1'b0;
      timeout_err <= 1'b0;
`ifdef AC97_HOST_PORT_EN
      ack <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
`endif
    end else begin
`ifdef AC97_HOST_PORT_EN
      ack <= 1'b0;
`endif
      if (!codec_ready) begin
        state <= WAIT_READY;
        idx <= '0;
        cnt <= '0;
        validate <= 1'b0;
        init_done <= 1'b0;
      end else
        case (state)
          WAIT_READY: state <= INIT_ISSUE;
          INIT_ISSUE: begin
            Register <= {1'b0, entry[22:16]};
            command <= entry[15:0];
            validate <= 1'b1;
            cnt <= '0;
            state <= INIT_WAIT;
          end
          INIT_WAIT:
            if (done_rise || expired) begin
              validate <= 1'b0;
              timeout_err <= timeout_err | ~done_rise;
              if (idx == LAST_IDX) begin
                init_done <= 1'b1;
                state <= ARB;
              end else begin
                idx <= idx + 3'd1;
                state <= INIT_ISSUE;
              end
            end else cnt <= cnt + 1'b1;
`ifdef AC97_HOST_PORT_EN
          ARB:
            if (host.host_req) begin
              hold_addr <= host.host_addr;
              hold_data <= host.host_data;
              state <= HOST_ISSUE;
            end
          HOST_ISSUE: begin
            Register <= {1'b0, hold_addr};
            command <= hold_data;
            validate <= 1'b1;
            cnt <= '0;
            state <= HOST_WAIT;
          end
          HOST_WAIT:
            if (done_rise || expired) begin
              validate <= 1'b0;
              timeout_err <= timeout_err | ~done_rise;
              ack <= 1'b1;
              state <= ARB;
            end else cnt <= cnt + 1'b1;
`else
          ARB: state <= ARB;
`endif
          default: state <= WAIT_READY;
        endcase
    end
endmodule
